// File: rtl/cfg_bus_initiator.sv
// cfg_bus_initiator
//   Bus initiator for the CFG_INT configuration register interface. Takes one read/write
//   command at a time from the host, runs a two-phase SETUP/ACCESS transfer to the slave and
//   returns read data or a timeout error on the response port.
//
//   Optional feature macro: CFG_INIT_RETRY_EN
//     defined   - the first timeout reissues the same transfer (back to SETUP); a second
//                 timeout reports rsp_err.
//     undefined - the first timeout reports rsp_err directly.
//
// Ports
//   clk, reset                 clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_we/cmd_addr/cmd_wdata qualify it
//   rsp_valid/rsp_ready        response handshake; rsp_rdata/rsp_err held until accepted
//   cfg_sel/cfg_enable         slave select (SETUP+ACCESS) and access strobe (ACCESS)
//   cfg_we/cfg_addr/cfg_wdata  transfer qualifiers to the slave, stable through ACCESS
//   cfg_rdata/cfg_ack          slave read data and completion, sampled only in ACCESS
module cfg_bus_initiator #(
   parameter int unsigned AW      = 8,
   parameter int unsigned DW      = 16,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_we,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic          cfg_sel,
   output logic          cfg_enable,
   output logic          cfg_we,
   output logic [AW-1:0] cfg_addr,
   output logic [DW-1:0] cfg_wdata,
   input  logic [DW-1:0] cfg_rdata,
   input  logic          cfg_ack
);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   // Counter value seen during the last allowed ACCESS cycle of an attempt.
   localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

   state_e          state_q, state_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            err_q, err_d;
   logic [7:0]      cnt_q, cnt_d;
`ifdef CFG_INIT_RETRY_EN
   logic            retry_q, retry_d;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
`ifdef CFG_INIT_RETRY_EN
         retry_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
`ifdef CFG_INIT_RETRY_EN
         retry_q <= retry_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
`ifdef CFG_INIT_RETRY_EN
      retry_d = retry_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               we_d    = cmd_we;
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
`ifdef CFG_INIT_RETRY_EN
               retry_d = 1'b0;
`endif
               state_d = StSetup;
            end
         end
         StSetup: begin
            cnt_d   = '0;
            state_d = StAccess;
         end
         StAccess: begin
            // Ack takes priority over a timeout in the same cycle.
            if (cfg_ack) begin
               rdata_d = we_q ? '0 : cfg_rdata;
               err_d   = 1'b0;
               state_d = StResp;
            end else if (cnt_q == CntLast) begin
`ifdef CFG_INIT_RETRY_EN
               if (!retry_q) begin
                  retry_d = 1'b1;
                  state_d = StSetup;
               end else begin
                  rdata_d = '0;
                  err_d   = 1'b1;
                  state_d = StResp;
               end
`else
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = StResp;
`endif
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StResp: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs decode from state; transfer and response fields are zero when not in use.
   always_comb begin
      cmd_ready  = (state_q == StIdle);
      cfg_sel    = (state_q == StSetup) || (state_q == StAccess);
      cfg_enable = (state_q == StAccess);
      rsp_valid  = (state_q == StResp);
      cfg_we     = cfg_sel & we_q;
      cfg_addr   = cfg_sel ? addr_q : '0;
      cfg_wdata  = cfg_sel ? wdata_q : '0;
      rsp_rdata  = rsp_valid ? rdata_q : '0;
      rsp_err    = rsp_valid & err_q;
   end

endmodule
